mem_arbiter: RTL

Sequential controller that shares the single byte-wide RAM port between instruction fetch (IF) and the load/store stage (MEM). The load/store address is the effective address computed by the execute stage. Each word, halfword or byte access is split into serial byte transfers. MEM is given priority over IF, and an in-flight fetch is aborted on a branch/jump redirect from the execute stage.

---
 rtl/mem_arbiter_if.sv | 30 +++
 rtl/mem_arbiter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the pipeline (IF / MEM stages), the arbiter and the byte-wide RAM.
interface mem_arbiter_if #(parameter int RAM_AW = 17);
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_done;
    logic [31:0]       if_inst;
    logic              mem_req;
    logic              mem_we;
    logic [1:0]        mem_size;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_done;
    logic [31:0]       mem_rdata;
    logic              flush;
    logic [7:0]        ram_din;
    logic [7:0]        ram_dout;
    logic [RAM_AW-1:0] ram_a;
    logic              ram_wr;
    logic              busy;

    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_size, mem_addr, mem_wdata, flush, ram_din,
        output if_done, if_inst, mem_done, mem_rdata, ram_dout, ram_a, ram_wr, busy
    );

    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_size, mem_addr, mem_wdata, flush, ram_din,
        input  if_done, if_inst, mem_done, mem_rdata, ram_dout, ram_a, ram_wr, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one byte-wide RAM port between instruction fetch and load/store,
// splitting each access into serial byte transfers; MEM has priority over IF.
module mem_arbiter #(
    parameter int RAM_AW = 17
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] IF_RD  = 2'd1;
    localparam logic [1:0] MEM_RD = 2'd2;
    localparam logic [1:0] MEM_WR = 2'd3;

    typedef struct packed {
        logic [RAM_AW-1:0] base;
        logic [2:0]        n;
        logic [3:0][7:0]   wdata;
    } xfer_t;

    logic [1:0]      state;
    logic [2:0]      cnt;
    xfer_t           xf;
    logic [3:0][7:0] data;
    logic            if_done_q, mem_done_q;
    logic [31:0]     if_inst_q, mem_rdata_q;

    logic            rd_state;
    logic [1:0]      idx;
    logic [1:0]      cap;
    logic [3:0][7:0] rd_word;
    logic            accept;

    function automatic logic [2:0] size_to_n(input logic [1:0] size);
        case (size)
            2'b00:   size_to_n = 3'd1;
            2'b01:   size_to_n = 3'd2;
            default: size_to_n = 3'd4;
        endcase
    endfunction

    assign rd_state = (state == IF_RD) || (state == MEM_RD);
    // In the capture-only read cycle (cnt==N) the address stays on the last byte.
    assign idx      = (rd_state && cnt == xf.n) ? 2'(cnt - 3'd1) : cnt[1:0];
    assign cap      = 2'(cnt - 3'd1);
    assign accept   = !if_done_q && !mem_done_q;

    always_comb begin
        rd_word      = data;
        rd_word[cap] = bus.ram_din;
    end

    // Adding in RAM_AW bits gives the same result as a 32-bit add then truncate.
    assign bus.ram_a     = xf.base + RAM_AW'(idx);
    assign bus.ram_wr    = (state == MEM_WR);
    assign bus.ram_dout  = xf.wdata[idx];
    assign bus.busy      = (state != IDLE);
    assign bus.if_done   = if_done_q;
    assign bus.mem_done  = mem_done_q;
    assign bus.if_inst   = if_inst_q;
    assign bus.mem_rdata = mem_rdata_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= 3'd0;
            xf          <= '0;
            data        <= '0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            if_inst_q   <= 32'd0;
            mem_rdata_q <= 32'd0;
        end else begin
            if_done_q  <= 1'b0;
            mem_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && bus.mem_req) begin
                        xf.base  <= bus.mem_addr[RAM_AW-1:0];
                        xf.n     <= size_to_n(bus.mem_size);
                        xf.wdata <= bus.mem_wdata;
                        cnt      <= 3'd0;
                        data     <= '0;
                        state    <= bus.mem_we ? MEM_WR : MEM_RD;
                    end else if (accept && bus.if_req && !bus.flush) begin
                        xf.base  <= bus.if_addr[RAM_AW-1:0];
                        xf.n     <= 3'd4;
                        xf.wdata <= '0;
                        cnt      <= 3'd0;
                        data     <= '0;
                        state    <= IF_RD;
                    end
                end
                IF_RD, MEM_RD: begin
                    if (state == IF_RD && bus.flush) begin
                        state <= IDLE;
                        cnt   <= 3'd0;
                    end else begin
                        if (cnt != 3'd0)
                            data <= rd_word;
                        if (cnt == xf.n) begin
                            state <= IDLE;
                            cnt   <= 3'd0;
                            if (state == IF_RD) begin
                                if_inst_q <= rd_word;
                                if_done_q <= 1'b1;
                            end else begin
                                mem_rdata_q <= rd_word;
                                mem_done_q  <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                end
                MEM_WR: begin
                    if (cnt == xf.n - 3'd1) begin
                        state      <= IDLE;
                        cnt        <= 3'd0;
                        mem_done_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
